// File: rtl/credit_counter.sv
// Credit counter: debounced coin inputs, bonus credits, start pulses and a saturating credit total.
// Optional CREDIT_COUNTER_FREE_PLAY_EN: starts are free, credit flags tied high, count kept for bookkeeping.
module credit_counter #(
  parameter int DEBOUNCE_CYCLES    = 572700,
  parameter int CREDIT_MAX         = 15,
  parameter int START_PULSE_CYCLES = 4
) (
  input  logic       i_clk_drv,
  input  logic       i_reset_n,
  input  logic       i_coin1_n,
  input  logic       i_coin2_n,
  input  logic       i_bonus_coin,
  input  logic       i_start1_n,
  input  logic       i_start2_n,
  input  logic       i_attract_n,
  output logic [3:0] o_credit_count,
  output logic       o_credit_1_or_more,
  output logic       o_credit_2_or_more,
  output logic       o_start_game1_n,
  output logic       o_start_game2_n
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(START_PULSE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HELD, ST_REL} coin_st_t;

  // bit order: {start2, start1, coin2, coin1}
  logic [3:0]    r_sync1, r_sync2;
  logic [1:0]    r_start_d;
  logic          r_bonus_prev, r_bonus_pulse;
  logic [3:0]    r_count;
  logic [PW-1:0] r_pulse_cnt;
  logic          r_start_game1_n, r_start_game2_n;
  logic [1:0]    w_accept;
  logic          w_req1, w_req2, w_can_start, w_afford1, w_afford2;
  logic          w_grant1, w_grant2;
  logic [5:0]    w_inc, w_dec, w_sum;
  logic [3:0]    w_count_nxt;

  always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1   <= 4'hF;
      r_sync2   <= 4'hF;
      r_start_d <= 2'b11;
    end else begin
      r_sync1   <= {i_start2_n, i_start1_n, i_coin2_n, i_coin1_n};
      r_sync2   <= r_sync1;
      r_start_d <= r_sync2[3:2];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_coin
    coin_st_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_low, w_acc;

    assign w_low       = ~r_sync2[g];
    assign w_accept[g] = w_acc;

    always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Accept fires on the cycle the count completes so the credit lands on the same edge.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc       = 1'b0;
      case (r_state)
        ST_IDLE: if (w_low) begin
          w_state_nxt = ST_ARM;
          w_cnt_nxt   = CW'(1);
        end
        ST_ARM: begin
          if (!w_low) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_acc       = 1'b1;
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_HELD: if (!w_low) begin
          w_state_nxt = ST_REL;
          w_cnt_nxt   = CW'(1);
        end
        ST_REL: begin
          if (w_low) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bonus_prev  <= 1'b0;
      r_bonus_pulse <= 1'b0;
    end else begin
      r_bonus_prev  <= i_bonus_coin;
      r_bonus_pulse <= i_bonus_coin & ~r_bonus_prev;
    end
  end

  assign w_req1      = r_start_d[0] & ~r_sync2[2];
  assign w_req2      = r_start_d[1] & ~r_sync2[3];
  assign w_can_start = ~i_attract_n & r_start_game1_n & r_start_game2_n;

`ifdef CREDIT_COUNTER_FREE_PLAY_EN
  assign w_afford1 = 1'b1;
  assign w_afford2 = 1'b1;
`else
  assign w_afford1 = (r_count >= 4'd1);
  assign w_afford2 = (r_count >= 4'd2);
`endif

  assign w_grant2 = w_can_start & w_req2 & w_afford2;
  assign w_grant1 = w_can_start & w_req1 & w_afford1 & ~w_grant2;

`ifdef CREDIT_COUNTER_FREE_PLAY_EN
  assign w_dec = 6'd0;
`else
  assign w_dec = w_grant2 ? 6'd2 : (w_grant1 ? 6'd1 : 6'd0);
`endif

  assign w_inc       = 6'(w_accept[0]) + 6'(w_accept[1]) + 6'(r_bonus_pulse);
  assign w_sum       = {2'b00, r_count} + w_inc - w_dec;
  assign w_count_nxt = (w_sum > 6'(CREDIT_MAX)) ? 4'(CREDIT_MAX) : w_sum[3:0];

  always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
    if (!i_reset_n) r_count <= 4'd0;
    else            r_count <= w_count_nxt;
  end

  // Pulse width is a down-counter loaded on grant; release when it has expired.
  always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_start_game1_n <= 1'b1;
      r_start_game2_n <= 1'b1;
      r_pulse_cnt     <= '0;
    end else if (w_grant2) begin
      r_start_game2_n <= 1'b0;
      r_pulse_cnt     <= PW'(START_PULSE_CYCLES - 1);
    end else if (w_grant1) begin
      r_start_game1_n <= 1'b0;
      r_pulse_cnt     <= PW'(START_PULSE_CYCLES - 1);
    end else if (!r_start_game1_n || !r_start_game2_n) begin
      if (r_pulse_cnt == '0) begin
        r_start_game1_n <= 1'b1;
        r_start_game2_n <= 1'b1;
      end else begin
        r_pulse_cnt <= r_pulse_cnt - PW'(1);
      end
    end
  end

  assign o_credit_count  = r_count;
  assign o_start_game1_n = r_start_game1_n;
  assign o_start_game2_n = r_start_game2_n;

`ifdef CREDIT_COUNTER_FREE_PLAY_EN
  assign o_credit_1_or_more = 1'b1;
  assign o_credit_2_or_more = 1'b1;
`else
  assign o_credit_1_or_more = (r_count >= 4'd1);
  assign o_credit_2_or_more = (r_count >= 4'd2);
`endif

endmodule
